// File: rtl/pulse_clock_monitor.sv
`timescale 1ns/1ps
// pulse_clock_monitor: qualifies an asynchronous pulse train, emits one tick
// per accepted pulse, measures its period and tracks lock / missing pulses.
// In : clk, rst_n (async low), pulse_in (async), clr (clears missing)
// Out: tick, period[22:0], period_valid, locked, missing, pulse_count[11:0]
module pulse_clock_monitor #(
  parameter int CLK_FREQ   = 100000000,
  parameter int FREQ       = 120000,
  parameter int TOL        = 16,
  parameter int LOCK_COUNT = 4,
  parameter int MIN_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pulse_in,
  input  logic        clr,
  output logic        tick,
  output logic [22:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        missing,
  output logic [11:0] pulse_count
);

  localparam int EXP     = CLK_FREQ / FREQ;
  localparam int TIMEOUT = 2 * EXP;
  localparam int LO      = (EXP > TOL) ? EXP - TOL : 0;
  localparam int HI      = EXP + TOL;
  localparam int WW      = $clog2(MIN_WIDTH + 1);
  localparam int GW      = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          s1_q, s_q;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          acc_q, acc_d;
  logic          tick_q, tick_d;
  logic [22:0]   pcnt_q, pcnt_d;
  logic [22:0]   period_q, period_d;
  logic [22:0]   period_new;
  logic          pv_q, pv_d;
  logic          locked_q, locked_d;
  logic          missing_q, missing_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [11:0]   cnt_q, cnt_d;
  logic          in_tol;
  logic          timeout;

  // Width filter: the high-run counter saturates so a long pulse
  // produces exactly one accept.
  always_comb begin
    wcnt_d = '0;
    if (s_q) begin
      if (wcnt_q == WW'(MIN_WIDTH)) wcnt_d = wcnt_q;
      else                          wcnt_d = wcnt_q + WW'(1);
    end
    acc_d  = s_q & (wcnt_q == WW'(MIN_WIDTH - 1));
    tick_d = acc_q;
  end

  // Measurement datapath, all driven by the registered accept.
  always_comb begin
    pcnt_d = pcnt_q;
    if (acc_q)        pcnt_d = '0;
    else if (~&pcnt_q) pcnt_d = pcnt_q + 23'd1;

    period_new = (&pcnt_q) ? pcnt_q : pcnt_q + 23'd1;
    in_tol     = (period_new >= 23'(LO)) && (period_new <= 23'(HI));

    good_inc = (good_q == GW'(LOCK_COUNT)) ? good_q : good_q + GW'(1);

    cnt_d = acc_q ? cnt_q + 12'd1 : cnt_q;

    // An accept on the timeout cycle suppresses the timeout.
    timeout = (state_q != IDLE) && !acc_q &&
              (pcnt_q == 23'(TIMEOUT - 1));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc_q) state_d = ARMED;
      end
      ARMED: begin
        if (acc_q)        state_d = TRACK;
        else if (timeout) state_d = IDLE;
      end
      TRACK: begin
        if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    period_d  = period_q;
    pv_d      = pv_q;
    locked_d  = locked_q;
    good_d    = good_q;
    missing_d = missing_q;
    if (clr) missing_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pv_d     = 1'b0;
        locked_d = 1'b0;
      end
      ARMED, TRACK: begin
        if (acc_q) begin
          period_d = period_new;
          pv_d     = 1'b1;
          // The first measured period seeds the run counter.
          if (!in_tol)              good_d = '0;
          else if (state_q == ARMED) good_d = GW'(1);
          else                      good_d = good_inc;
          locked_d = (good_d == GW'(LOCK_COUNT));
        end else if (timeout) begin
          missing_d = 1'b1;
          locked_d  = 1'b0;
          pv_d      = 1'b0;
          good_d    = '0;
        end
      end
      default: begin
        pv_d     = 1'b0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s_q       <= 1'b0;
      wcnt_q    <= '0;
      acc_q     <= 1'b0;
      tick_q    <= 1'b0;
      pcnt_q    <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      missing_q <= 1'b0;
      good_q    <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= pulse_in;
      s_q       <= s1_q;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      missing_q <= missing_d;
      good_q    <= good_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign missing      = missing_q;
  assign pulse_count  = cnt_q;

endmodule

// File: tb/tb_pulse_clock_monitor.sv
`timescale 1ns/1ps
// tb_pulse_clock_monitor: random pulse trains against an
// event-level model of accepts, periods, lock and timeout.
module tb_pulse_clock_monitor;

  localparam int EXP = 833;
  localparam int TOL = 16;
  localparam int LC  = 4;
  localparam int MW  = 4;
  localparam int TMO = 2 * EXP;
  localparam int LAT = MW + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pulse_in = 1'b0;
  logic        clr = 1'b0;
  logic        tick;
  logic [22:0] period;
  logic        period_valid;
  logic        locked;
  logic        missing;
  logic [11:0] pulse_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int m_phase, m_last, m_period, m_good, m_count;
  bit m_pv, m_locked, m_missing;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_clock_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .clr          (clr),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .missing      (missing),
    .pulse_count  (pulse_count)
  );

  function automatic logic [37:0] obs();
    return {period, period_valid, locked, missing, pulse_count};
  endfunction

  function automatic logic [37:0] expv();
    return {23'(m_period), m_pv, m_locked, m_missing, 12'(m_count)};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_last = 0; m_period = 0; m_good = 0;
    m_count = 0; m_pv = 0; m_locked = 0; m_missing = 0;
  endtask

  // Silence of TMO cycles since the last accept drops back to idle.
  task automatic m_at(input int t);
    if (m_phase > 0 && t >= m_last + TMO) begin
      m_phase = 0; m_missing = 1; m_locked = 0;
      m_pv = 0; m_good = 0;
    end
  endtask

  task automatic m_accept(input int ta);
    int n;
    bit ok;
    m_at(ta - 1);
    m_count = (m_count + 1) % 4096;
    if (m_phase == 0) begin
      m_phase = 1;
    end else begin
      n = ta - m_last;
      m_period = n;
      m_pv = 1;
      ok = (n >= EXP - TOL) && (n <= EXP + TOL);
      if (!ok)              m_good = 0;
      else if (m_phase == 1) m_good = 1;
      else                  m_good = (m_good < LC) ? m_good + 1 : LC;
      m_locked = (m_good == LC);
      m_phase = 2;
    end
    m_last = ta;
  endtask

  // Called just after a negedge; drives w high cycles then g low.
  task automatic pulse(input int w, input int g, output int tk);
    tk = -1;
    pulse_in = 1'b1;
    for (int i = 0; i < w + g; i++) begin
      @(negedge clk);
      if (i == w - 1) pulse_in = 1'b0;
      if (tick) tk = cyc;
    end
  endtask

  task automatic send(input int w, input int g,
                      output int tk, output int etk);
    int t0;
    t0 = cyc;
    etk = (w >= MW) ? t0 + LAT : -1;
    pulse(w, g, tk);
    if (w >= MW) m_accept(t0 + LAT);
    m_at(cyc);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
    m_at(cyc);
  endtask

  task automatic test_reset();
    int tk, etk;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tick, obs()} !== 39'd0) begin
      bad++;
      $display("FAIL reset_init got=%h want=0", {tick, obs()});
    end
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send($urandom_range(4, 9), EXP - 9, tk, etk);
      total++;
      if (tk !== etk) begin
        bad++;
        $display("FAIL reset_tick%0d got=%0d want=%0d", k, tk, etk);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL reset_out%0d got=%h want=%h", k, obs(), expv());
      end
    end
    wait_to(cyc + 100);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tick, obs()} !== 39'd0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", {tick, obs()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_lock();
    int tk, etk;
    for (int k = 0; k < 6; k++) begin
      send(9, EXP - 9, tk, etk);
      total++;
      if (tk !== etk) begin
        bad++;
        $display("FAIL lock_tick%0d got=%0d want=%0d", k, tk, etk);
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL lock_out%0d got=%h want=%h", k, obs(), expv());
      end
      total++;
      if (locked !== (k >= 4)) begin
        bad++;
        $display("FAIL lock_rise%0d got=%b want=%b", k, locked, k >= 4);
      end
    end
  endtask

  task automatic test_unlock();
    int tk, etk, w, sp;
    send(9, 900 - 9, tk, etk);
    send(9, EXP - 9, tk, etk);
    total++;
    if (locked !== 1'b0 || period !== 23'd900) begin
      bad++;
      $display("FAIL unlock_fall got=%b/%0d want=0/900", locked, period);
    end
    for (int j = 0; j < 4; j++) begin
      w = $urandom_range(4, 9);
      send(w, EXP - w, tk, etk);
      total++;
      if (obs() !== expv() || locked !== (j == 3)) begin
        bad++;
        $display("FAIL relock%0d got=%h want=%h", j, obs(), expv());
      end
    end
    for (int j = 0; j < 4; j++) begin
      w  = $urandom_range(4, 9);
      sp = EXP - TOL + $urandom_range(0, 2 * TOL);
      send(w, sp - w, tk, etk);
      total++;
      if (tk !== etk || obs() !== expv()) begin
        bad++;
        $display("FAIL jitter%0d got=%h/%0d want=%h/%0d",
                 j, obs(), tk, expv(), etk);
      end
    end
  endtask

  task automatic test_glitch();
    int tk, etk, w, g1, gw1, gp1, gw2, sp;
    for (int j = 0; j < 3; j++) begin
      sp  = EXP - TOL + $urandom_range(0, 2 * TOL);
      w   = $urandom_range(4, 9);
      g1  = $urandom_range(100, 300);
      gw1 = $urandom_range(1, MW - 1);
      gp1 = $urandom_range(100, 300);
      gw2 = $urandom_range(1, MW - 1);
      send(w, g1, tk, etk);
      total++;
      if (tk !== etk || obs() !== expv()) begin
        bad++;
        $display("FAIL glitch_good%0d got=%h/%0d want=%h/%0d",
                 j, obs(), tk, expv(), etk);
      end
      send(gw1, gp1, tk, etk);
      total++;
      if (tk !== -1 || obs() !== expv()) begin
        bad++;
        $display("FAIL glitch_a%0d got=%h/%0d want=%h/-1",
                 j, obs(), tk, expv());
      end
      send(gw2, sp - w - g1 - gw1 - gp1 - gw2, tk, etk);
      total++;
      if (tk !== -1 || obs() !== expv()) begin
        bad++;
        $display("FAIL glitch_b%0d got=%h/%0d want=%h/-1",
                 j, obs(), tk, expv());
      end
    end
  endtask

  task automatic test_missing();
    int tk, etk, ta;
    send(9, EXP - 9, tk, etk);
    ta = m_last;
    wait_to(ta + TMO - 1);
    total++;
    if (missing !== 1'b0 || obs() !== expv()) begin
      bad++;
      $display("FAIL miss_early got=%h want=%h", obs(), expv());
    end
    @(negedge clk);
    m_at(cyc);
    total++;
    if ({missing, locked, period_valid} !== 3'b100 ||
        obs() !== expv()) begin
      bad++;
      $display("FAIL miss_set got=%h want=%h", obs(), expv());
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_missing = 0;
    total++;
    if (missing !== 1'b0) begin
      bad++;
      $display("FAIL miss_clr got=%b want=0", missing);
    end
    for (int k = 0; k < 6; k++) begin
      send(9, EXP - 9, tk, etk);
      total++;
      if (tk !== etk || obs() !== expv() || locked !== (k >= 4)) begin
        bad++;
        $display("FAIL restart%0d got=%h/%0d want=%h/%0d",
                 k, obs(), tk, expv(), etk);
      end
    end
    ta = m_last;
    wait_to(ta + TMO - 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_at(cyc);
    total++;
    if (missing !== 1'b1 || obs() !== expv()) begin
      bad++;
      $display("FAIL clr_vs_set got=%h want=%h", obs(), expv());
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_missing = 0;
    total++;
    if (missing !== 1'b0) begin
      bad++;
      $display("FAIL clr_after got=%b want=0", missing);
    end
  endtask

  task automatic test_wrap();
    int tk, etk;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 4097; k++) begin
      send($urandom_range(MW, MW + 1), $urandom_range(4, 5), tk, etk);
      total++;
      if (tk !== etk) begin
        bad++;
        $display("FAIL wrap_tick%0d got=%0d want=%0d", k, tk, etk);
      end
    end
    total++;
    if (pulse_count !== 12'd1 || obs() !== expv()) begin
      bad++;
      $display("FAIL wrap_count got=%h want=%h", obs(), expv());
    end
    send(9, TMO - 9, tk, etk);
    send(9, TMO - 9, tk, etk);
    total++;
    if (missing !== 1'b0 || period !== 23'(TMO) ||
        obs() !== expv()) begin
      bad++;
      $display("FAIL edge_accept got=%h want=%h", obs(), expv());
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    test_reset();
    test_lock();
    test_unlock();
    test_glitch();
    test_missing();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
